// File: rtl/instr_seq_decoder_if.sv
// Fetch-to-decoder handshake and control-bus bundle.
// Fetch side is master; the decoder is slave.
interface instr_seq_decoder_if #(
  parameter int IR_W   = 8,
  parameter int CTRL_W = 16
);

  logic [IR_W-1:0]   ir;
  logic              ir_valid;
  logic              ir_ready;
  logic              stall;
  logic [CTRL_W-1:0] ctrl_sig;
  logic [2:0]        cycle;
  logic              busy;
  logic              done;
  logic              illegal;
  logic              halted;

  modport master (
    output ir,
    output ir_valid,
    output stall,
    input  ir_ready,
    input  ctrl_sig,
    input  cycle,
    input  busy,
    input  done,
    input  illegal,
    input  halted
  );

  modport slave (
    input  ir,
    input  ir_valid,
    input  stall,
    output ir_ready,
    output ctrl_sig,
    output cycle,
    output busy,
    output done,
    output illegal,
    output halted
  );

endinterface

// File: rtl/instr_seq_decoder.sv
// Multi-cycle instruction sequencer/decoder.
// Emits registered control words per execute cycle.
module instr_seq_decoder #(
  parameter int IR_W    = 8,
  parameter int CTRL_W  = 16,
  parameter int MUL_CYC = 4
) (
  input logic                sys_clock,
  input logic                rst,
  instr_seq_decoder_if.slave bus
);

  if (IR_W < 8) begin : g_bad_ir_w
    $error("IR_W must be >= 8");
  end
  if (CTRL_W < 9) begin : g_bad_ctrl_w
    $error("CTRL_W must be >= 9");
  end
  if (MUL_CYC < 2 || MUL_CYC > 8) begin : g_bad_mul
    $error("MUL_CYC must be in 2..8");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_LOAD,
    OP_ADD,
    OP_STORE,
    OP_JMP,
    OP_HALT,
    OP_MUL,
    OP_BAD
  } op_e;

  localparam logic [2:0] MUL_LAST = 3'(MUL_CYC - 1);

  state_e            state;
  op_e               cur_op;
  op_e               dec_op;
  logic [CTRL_W-1:0] ctrl_q;
  logic [2:0]        cyc_q;
  logic              busy_q;
  logic              illegal_q;
  logic              halted_q;
  logic [7:0]        code;
  logic              done;
  logic              ready;
  logic              accept;

  function automatic logic [2:0] last_of(op_e op);
    logic [2:0] l;
    case (op)
      OP_LOAD: l = 3'd1;
      OP_ADD:  l = 3'd1;
      OP_MUL:  l = MUL_LAST;
      default: l = 3'd0;
    endcase
    return l;
  endfunction

  function automatic logic [8:0] pat(
    op_e        op,
    logic [2:0] idx
  );
    logic [8:0] w;
    case (op)
      OP_LOAD:  w = (idx == 3'd0) ? 9'h001 : 9'h018;
      OP_ADD:   w = (idx == 3'd0) ? 9'h002 : 9'h030;
      OP_STORE: w = 9'h004;
      OP_JMP:   w = 9'h040;
      OP_MUL:   w = (idx == MUL_LAST) ? 9'h030 : 9'h100;
      default:  w = 9'h000;
    endcase
    return w;
  endfunction

  // Any set bit above the low byte forces an illegal code.
  assign code = ((bus.ir >> 8) != '0) ? 8'hFF : bus.ir[7:0];

  always_comb begin
    dec_op = OP_BAD;
    unique case (1'b1)
      code == 8'h00: dec_op = OP_NOP;
      code == 8'h01: dec_op = OP_LOAD;
      code == 8'h02: dec_op = OP_ADD;
      code == 8'h03: dec_op = OP_STORE;
      code == 8'h04: dec_op = OP_JMP;
      code == 8'h05: dec_op = OP_HALT;
      code == 8'h06: dec_op = OP_MUL;
      default:       dec_op = OP_BAD;
    endcase
  end

  assign done   = (state == S_EXEC) && (cyc_q == last_of(cur_op));
  assign ready  = !rst && ((state == S_IDLE) || (done && !bus.stall));
  assign accept = bus.ir_valid && ready;

  always_ff @(posedge sys_clock) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_op    <= OP_NOP;
      ctrl_q    <= '0;
      cyc_q     <= '0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else if (state != S_HALT &&
                 !(state == S_EXEC && bus.stall)) begin
      illegal_q <= 1'b0;
      if (accept) begin
        case (dec_op)
          OP_BAD: begin
            state     <= S_IDLE;
            ctrl_q    <= '0;
            cyc_q     <= '0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b1;
          end
          OP_HALT: begin
            state    <= S_HALT;
            ctrl_q   <= CTRL_W'(9'h080);
            cyc_q    <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end
          default: begin
            state  <= S_EXEC;
            cur_op <= dec_op;
            ctrl_q <= CTRL_W'(pat(dec_op, 3'd0));
            cyc_q  <= '0;
            busy_q <= 1'b1;
          end
        endcase
      end else if (state == S_EXEC) begin
        if (done) begin
          state  <= S_IDLE;
          ctrl_q <= '0;
          cyc_q  <= '0;
          busy_q <= 1'b0;
        end else begin
          cyc_q  <= cyc_q + 3'd1;
          ctrl_q <= CTRL_W'(pat(cur_op, cyc_q + 3'd1));
        end
      end
    end
  end

  assign bus.ir_ready = ready;
  assign bus.ctrl_sig = ctrl_q;
  assign bus.cycle    = cyc_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done;
  assign bus.illegal  = illegal_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_instr_seq_decoder.sv
// Bench for instr_seq_decoder: two instances (IR_W=12/MUL=4, IR_W=8/MUL=2)
// driven in lockstep and checked against a cycle-list reference model.
module tb_instr_seq_decoder;

  logic sys_clock = 1'b0;
  logic rst;
  always #5 sys_clock = ~sys_clock;

  instr_seq_decoder_if #(.IR_W(12), .CTRL_W(16)) b0 ();
  instr_seq_decoder_if #(.IR_W(8),  .CTRL_W(16)) b1 ();

  instr_seq_decoder #(
    .IR_W(12), .CTRL_W(16), .MUL_CYC(4)
  ) dut0 (
    .sys_clock(sys_clock),
    .rst(rst),
    .bus(b0)
  );

  instr_seq_decoder #(
    .IR_W(8), .CTRL_W(16), .MUL_CYC(2)
  ) dut1 (
    .sys_clock(sys_clock),
    .rst(rst),
    .bus(b1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic        cur_v;
  logic [11:0] cur_ir;
  logic        cur_st;

  int          mulc   [2] = '{4, 2};
  int          m_op   [2];
  int          m_cyc  [2];
  bit          m_busy [2];
  bit          m_halt [2];
  bit          m_ill  [2];
  logic [15:0] m_ctrl [2];

  function automatic int n_cyc(int op, int mc);
    case (op)
      1, 2:    return 2;
      6:       return mc;
      default: return 1;
    endcase
  endfunction

  function automatic logic [15:0] word(int op, int i, int mc);
    case (op)
      1:       return (i == 0) ? 16'h0001 : 16'h0018;
      2:       return (i == 0) ? 16'h0002 : 16'h0030;
      3:       return 16'h0004;
      4:       return 16'h0040;
      6:       return (i < mc - 1) ? 16'h0100 : 16'h0030;
      default: return 16'h0000;
    endcase
  endfunction

  // -1 marks an illegal opcode for instance k's IR width.
  function automatic int op_of(logic [11:0] v, int k);
    logic [11:0] e;
    e = (k == 1) ? {4'h0, v[7:0]} : v;
    return (e <= 12'd6) ? int'(e) : -1;
  endfunction

  function automatic bit m_done(int k);
    return m_busy[k] && (m_cyc[k] == n_cyc(m_op[k], mulc[k]) - 1);
  endfunction

  function automatic bit m_ready(int k);
    return !rst && !m_halt[k] &&
           (!m_busy[k] || (m_done(k) && !cur_st));
  endfunction

  task automatic model_edge(input int k);
    int op;
    if (rst) begin
      m_op[k]   = 0;
      m_cyc[k]  = 0;
      m_busy[k] = 0;
      m_halt[k] = 0;
      m_ill[k]  = 0;
      m_ctrl[k] = '0;
    end else if (!m_halt[k] && !(m_busy[k] && cur_st)) begin
      if (cur_v && m_ready(k)) begin
        m_ill[k] = 0;
        op = op_of(cur_ir, k);
        if (op < 0) begin
          m_ctrl[k] = '0;
          m_busy[k] = 0;
          m_cyc[k]  = 0;
          m_ill[k]  = 1;
        end else if (op == 5) begin
          m_ctrl[k] = 16'h0080;
          m_halt[k] = 1;
          m_busy[k] = 0;
          m_cyc[k]  = 0;
        end else begin
          m_op[k]   = op;
          m_cyc[k]  = 0;
          m_busy[k] = 1;
          m_ctrl[k] = word(op, 0, mulc[k]);
        end
      end else begin
        m_ill[k] = 0;
        if (m_busy[k]) begin
          if (m_done(k)) begin
            m_ctrl[k] = '0;
            m_busy[k] = 0;
            m_cyc[k]  = 0;
          end else begin
            m_cyc[k]  = m_cyc[k] + 1;
            m_ctrl[k] = word(m_op[k], m_cyc[k], mulc[k]);
          end
        end
      end
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] o,
    input logic [31:0] e
  );
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  task automatic obs(
    input  int          k,
    output logic        rdy,
    output logic        dn,
    output logic        bsy,
    output logic        ill,
    output logic        hlt,
    output logic [2:0]  cy,
    output logic [15:0] cs
  );
    if (k == 0) begin
      rdy = b0.ir_ready; dn = b0.done; bsy = b0.busy;
      ill = b0.illegal; hlt = b0.halted;
      cy = b0.cycle; cs = b0.ctrl_sig;
    end else begin
      rdy = b1.ir_ready; dn = b1.done; bsy = b1.busy;
      ill = b1.illegal; hlt = b1.halted;
      cy = b1.cycle; cs = b1.ctrl_sig;
    end
  endtask

  task automatic check_all(input int k, input bit post);
    logic rdy, dn, bsy, ill, hlt;
    logic [2:0] cy;
    logic [15:0] cs;
    string p;
    obs(k, rdy, dn, bsy, ill, hlt, cy, cs);
    p = $sformatf("d%0d_%s", k, post ? "post" : "pre");
    chk({p, "_ready"}, 32'(rdy), 32'(m_ready(k)));
    chk({p, "_done"}, 32'(dn), 32'(m_done(k)));
    if (post) begin
      chk({p, "_ctrl"}, 32'(cs), 32'(m_ctrl[k]));
      chk({p, "_cycle"}, 32'(cy), 32'(m_cyc[k]));
      chk({p, "_busy"}, 32'(bsy), 32'(m_busy[k]));
      chk({p, "_illegal"}, 32'(ill), 32'(m_ill[k]));
      chk({p, "_halted"}, 32'(hlt), 32'(m_halt[k]));
    end
  endtask

  task automatic drive(
    input logic        v,
    input logic [11:0] ir,
    input logic        st,
    input logic        r
  );
    cur_v = v; cur_ir = ir; cur_st = st; rst = r;
    b0.ir_valid = v; b0.ir = ir; b0.stall = st;
    b1.ir_valid = v; b1.ir = ir[7:0]; b1.stall = st;
  endtask

  task automatic step(
    input logic        v,
    input logic [11:0] ir,
    input logic        st,
    input logic        r
  );
    @(negedge sys_clock);
    drive(v, ir, st, r);
    #1;
    check_all(0, 1'b0);
    check_all(1, 1'b0);
    @(posedge sys_clock);
    model_edge(0);
    model_edge(1);
    #1;
    check_all(0, 1'b1);
    check_all(1, 1'b1);
  endtask

  function automatic logic [11:0] rnd_ir();
    int p;
    int legal [6] = '{0, 1, 2, 3, 4, 6};
    p = $urandom_range(0, 99);
    if (p < 70) return 12'(legal[$urandom_range(0, 5)]);
    if (p < 73) return 12'h005;
    if (p < 85) return 12'($urandom_range(7, 255));
    return 12'(($urandom_range(1, 15) << 8) + $urandom_range(0, 6));
  endfunction

  initial begin
    drive(1'b1, 12'h001, 1'b0, 1'b1);
    @(posedge sys_clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_op[k] = 0; m_cyc[k] = 0; m_busy[k] = 0;
      m_halt[k] = 0; m_ill[k] = 0; m_ctrl[k] = '0;
    end

    // reset held with a valid instruction offered
    step(1'b1, 12'h001, 1'b0, 1'b1);
    step(1'b1, 12'h001, 1'b0, 1'b1);
    chk("rst_ctrl", 32'(b0.ctrl_sig), 32'h0);
    chk("rst_ready", 32'(b0.ir_ready), 32'h0);
    step(1'b0, 12'h000, 1'b0, 1'b0);
    chk("rst_release_ready", 32'(b0.ir_ready), 32'h1);

    // LOAD
    step(1'b1, 12'h001, 1'b0, 1'b0);
    chk("load_c0", 32'(b0.ctrl_sig), 32'h0001);
    chk("load_c0_done", 32'(b0.done), 32'h0);
    step(1'b0, 12'h000, 1'b0, 1'b0);
    chk("load_c1", 32'(b0.ctrl_sig), 32'h0018);
    chk("load_c1_done", 32'(b0.done), 32'h1);
    step(1'b0, 12'h000, 1'b0, 1'b0);
    chk("load_end_busy", 32'(b0.busy), 32'h0);

    // ADD then STORE, stalled in ADD final cycle
    step(1'b1, 12'h002, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b0);
    repeat (3) begin
      step(1'b1, 12'h003, 1'b1, 1'b0);
      chk("stall_ctrl", 32'(b0.ctrl_sig), 32'h0030);
      chk("stall_ready", 32'(b0.ir_ready), 32'h0);
    end
    step(1'b1, 12'h003, 1'b0, 1'b0);
    chk("b2b_store", 32'(b0.ctrl_sig), 32'h0004);
    step(1'b0, 12'h000, 1'b0, 1'b0);

    // MUL: dut0 four cycles, dut1 two cycles
    step(1'b1, 12'h006, 1'b0, 1'b0);
    chk("mul4_c0", 32'(b0.ctrl_sig), 32'h0100);
    chk("mul2_c0", 32'(b1.ctrl_sig), 32'h0100);
    step(1'b0, 12'h000, 1'b0, 1'b0);
    chk("mul4_c1", 32'(b0.ctrl_sig), 32'h0100);
    chk("mul2_c1", 32'(b1.ctrl_sig), 32'h0030);
    chk("mul2_done", 32'(b1.done), 32'h1);
    step(1'b0, 12'h000, 1'b0, 1'b0);
    chk("mul4_c2", 32'(b0.ctrl_sig), 32'h0100);
    step(1'b0, 12'h000, 1'b0, 1'b0);
    chk("mul4_c3", 32'(b0.ctrl_sig), 32'h0030);
    chk("mul4_cycle", 32'(b0.cycle), 32'h3);
    chk("mul4_done", 32'(b0.done), 32'h1);
    step(1'b0, 12'h000, 1'b0, 1'b0);

    // illegal opcodes, then a normal STORE
    step(1'b1, 12'h0FF, 1'b0, 1'b0);
    chk("ill_ff", 32'(b0.illegal), 32'h1);
    chk("ill_ff_ctrl", 32'(b0.ctrl_sig), 32'h0);
    step(1'b1, 12'h101, 1'b0, 1'b0);
    chk("ill_101", 32'(b0.illegal), 32'h1);
    step(1'b1, 12'h003, 1'b0, 1'b0);
    chk("ill_after_store", 32'(b0.ctrl_sig), 32'h0004);
    chk("ill_cleared", 32'(b0.illegal), 32'h0);
    step(1'b0, 12'h000, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b0);

    // HALT is sticky until reset
    step(1'b1, 12'h005, 1'b0, 1'b0);
    chk("halt_ctrl", 32'(b0.ctrl_sig), 32'h0080);
    chk("halt_flag", 32'(b0.halted), 32'h1);
    repeat (10) begin
      step(1'b1, rnd_ir(), 1'($urandom_range(0, 1)), 1'b0);
      chk("halt_ready", 32'(b0.ir_ready), 32'h0);
    end
    step(1'b0, 12'h000, 1'b0, 1'b1);
    chk("halt_rst_ctrl", 32'(b0.ctrl_sig), 32'h0);
    chk("halt_rst_flag", 32'(b0.halted), 32'h0);

    // reset mid-MUL
    step(1'b1, 12'h006, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    chk("mulrst_ctrl", 32'(b0.ctrl_sig), 32'h0);
    chk("mulrst_busy", 32'(b0.busy), 32'h0);
    chk("mulrst_cycle", 32'(b0.cycle), 32'h0);

    // random traffic
    repeat (2000) begin
      int rp;
      rp = (m_halt[0] || m_halt[1]) ? 10 : 2;
      step(1'($urandom_range(0, 99) < 60), rnd_ir(),
           1'($urandom_range(0, 99) < 25),
           1'($urandom_range(0, 99) < rp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
